// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe: operation request in, held result and
// flags out, each side with a valid/ready handshake.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             c_new;
   logic             dc_new;
   logic             z_new;

   modport slave (
      input  in_valid, op, op_a, op_b, c_in, out_ready,
      output in_ready, out_valid, result, result_hi, c_new, dc_new, z_new
   );

   modport master (
      output in_valid, op, op_a, op_b, c_in, out_ready,
      input  in_ready, out_valid, result, result_hi, c_new, dc_new, z_new
   );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU: one-cycle logic/arithmetic ops, WIDTH-cycle shift-add
// multiply; result and C/DC/Z flags held in DONE until the consumer takes them.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   alu_pipe_if.slave   bus
);
   localparam int HALF  = WIDTH / 2;
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [3:0] OP_IOR  = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_COMP = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_INC  = 4'd6;
   localparam logic [3:0] OP_DEC  = 4'd7;
   localparam logic [3:0] OP_RLF  = 4'd8;
   localparam logic [3:0] OP_RRF  = 4'd9;
   localparam logic [3:0] OP_SWAP = 4'd10;
   localparam logic [3:0] OP_CLR  = 4'd12;
   localparam logic [3:0] OP_MUL  = 4'd13;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Returns {carry out of MSB, carry out of bit HALF-1, sum}.
   function automatic logic [WIDTH+1:0] add_cy(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             ci);
      logic [WIDTH:0] full;
      logic [HALF:0]  low;
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      low  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, ci};
      return {full[WIDTH], low[HALF], full[WIDTH-1:0]};
   endfunction

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   logic               c_q, c_d;
   logic               dc_q, dc_d;
   logic               z_q, z_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [WIDTH+1:0]   sum_s;
   logic [WIDTH+1:0]   diff_s;
   logic [2*WIDTH-1:0] acc_next_s;
   logic [WIDTH-1:0]   alu_res_s;
   logic               alu_c_s;
   logic               alu_dc_s;
   logic               accept_s;

   assign sum_s      = add_cy(bus.op_a, bus.op_b, 1'b0);
   assign diff_s     = add_cy(bus.op_a, ~bus.op_b, 1'b1);
   assign acc_next_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   assign accept_s   = bus.in_valid & (state_q == S_IDLE);

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.c_new     = c_q;
   assign bus.dc_new    = dc_q;
   assign bus.z_new     = z_q;

   // Single-cycle datapath; flags not touched by an op keep their registered value.
   always_comb begin
      alu_res_s = bus.op_a;
      alu_c_s   = c_q;
      alu_dc_s  = dc_q;
      case (bus.op)
         OP_IOR:  alu_res_s = bus.op_a | bus.op_b;
         OP_AND:  alu_res_s = bus.op_a & bus.op_b;
         OP_XOR:  alu_res_s = bus.op_a ^ bus.op_b;
         OP_COMP: alu_res_s = ~bus.op_a;
         OP_ADD: begin
            alu_res_s = sum_s[WIDTH-1:0];
            alu_c_s   = sum_s[WIDTH+1];
            alu_dc_s  = sum_s[WIDTH];
         end
         OP_SUB: begin
            alu_res_s = diff_s[WIDTH-1:0];
            alu_c_s   = diff_s[WIDTH+1];
            alu_dc_s  = diff_s[WIDTH];
         end
         OP_INC:  alu_res_s = bus.op_a + WIDTH'(1);
         OP_DEC:  alu_res_s = bus.op_a - WIDTH'(1);
         OP_RLF: begin
            alu_res_s = {bus.op_a[WIDTH-2:0], bus.c_in};
            alu_c_s   = bus.op_a[WIDTH-1];
         end
         OP_RRF: begin
            alu_res_s = {bus.c_in, bus.op_a[WIDTH-1:1]};
            alu_c_s   = bus.op_a[0];
         end
         OP_SWAP: alu_res_s = {bus.op_a[HALF-1:0], bus.op_a[WIDTH-1:HALF]};
         OP_CLR:  alu_res_s = {WIDTH{1'b0}};
         default: alu_res_s = bus.op_a;
      endcase
   end

   // Next-state and register-input logic for the IDLE/MUL/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      c_d         = c_q;
      dc_d        = dc_q;
      z_d         = z_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               if (bus.op == OP_MUL) begin
                  acc_d    = {(2*WIDTH){1'b0}};
                  mcand_d  = {{WIDTH{1'b0}}, bus.op_a};
                  mplier_d = bus.op_b;
                  cnt_d    = {CNT_W{1'b0}};
                  state_d  = S_MUL;
               end else begin
                  result_d    = alu_res_s;
                  result_hi_d = {WIDTH{1'b0}};
                  c_d         = alu_c_s;
                  dc_d        = alu_dc_s;
                  z_d         = (alu_res_s == {WIDTH{1'b0}});
                  state_d     = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            acc_d    = acc_next_s;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            // Last multiplier bit consumed: publish the product from the final partial sum.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d    = acc_next_s[WIDTH-1:0];
               result_hi_d = acc_next_s[2*WIDTH-1:WIDTH];
               c_d         = (acc_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
               z_d         = (acc_next_s == {(2*WIDTH){1'b0}});
               state_d     = S_DONE;
            end else begin
               state_d = S_MUL;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         result_q    <= {WIDTH{1'b0}};
         result_hi_q <= {WIDTH{1'b0}};
         c_q         <= 1'b0;
         dc_q        <= 1'b0;
         z_q         <= 1'b0;
         acc_q       <= {(2*WIDTH){1'b0}};
         mcand_q     <= {(2*WIDTH){1'b0}};
         mplier_q    <= {WIDTH{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         c_q         <= c_d;
         dc_q        <= dc_d;
         z_q         <= z_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed test of alu_pipe (WIDTH=8) with hand-computed expected values.
module tb_alu_pipe;
   logic clk;
   logic rst;
   int   n_asserts;
   int   n_fail;

   alu_pipe_if #(.WIDTH(8)) bus_if ();

   alu_pipe #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                            input logic c, input logic dc, input logic z);
      check({tag, " out_valid"}, 16'(bus_if.out_valid), 16'd1);
      check({tag, " result"},    16'(bus_if.result),    16'(res));
      check({tag, " result_hi"}, 16'(bus_if.result_hi), 16'(hi));
      check({tag, " c"},         16'(bus_if.c_new),     16'(c));
      check({tag, " dc"},        16'(bus_if.dc_new),    16'(dc));
      check({tag, " z"},         16'(bus_if.z_new),     16'(z));
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin);
      bus_if.in_valid = 1'b1;
      bus_if.op       = op;
      bus_if.op_a     = a;
      bus_if.op_b     = b;
      bus_if.c_in     = cin;
      tick();
      bus_if.in_valid = 1'b0;
   endtask

   task automatic take(input string tag);
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      check({tag, " in_ready after take"},  16'(bus_if.in_ready),  16'd1);
      check({tag, " out_valid after take"}, 16'(bus_if.out_valid), 16'd0);
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      rst = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
      bus_if.op        = 4'd0;
      bus_if.op_a      = 8'd0;
      bus_if.op_b      = 8'd0;
      bus_if.c_in      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("reset in_ready",  16'(bus_if.in_ready),  16'd1);
      check("reset out_valid", 16'(bus_if.out_valid), 16'd0);
      check("reset result",    16'(bus_if.result),    16'd0);
      check("reset result_hi", 16'(bus_if.result_hi), 16'd0);
      check("reset flags",     16'({bus_if.c_new, bus_if.dc_new, bus_if.z_new}), 16'd0);

      issue(4'd4, 8'h0F, 8'h01, 1'b0);
      check_out("add", 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
      take("add");

      issue(4'd5, 8'h05, 8'h05, 1'b0);
      check_out("sub_eq", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
      take("sub_eq");
      issue(4'd6, 8'hFF, 8'h00, 1'b0);
      check_out("inc", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
      take("inc");

      issue(4'd13, 8'h10, 8'h10, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("mul wait%0d out_valid", i), 16'(bus_if.out_valid), 16'd0);
         check($sformatf("mul wait%0d in_ready", i),  16'(bus_if.in_ready),  16'd0);
         tick();
      end
      check_out("mul_10x10", 8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
      check("mul in_ready done", 16'(bus_if.in_ready), 16'd0);
      take("mul_10x10");

      issue(4'd13, 8'hFF, 8'hFF, 1'b0);
      repeat (8) tick();
      check_out("mul_ffxff", 8'h01, 8'hFE, 1'b1, 1'b1, 1'b0);
      take("mul_ffxff");
      issue(4'd13, 8'h00, 8'h05, 1'b0);
      repeat (8) tick();
      check_out("mul_zero", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
      take("mul_zero");

      issue(4'd8, 8'h80, 8'h00, 1'b1);
      check_out("rlf", 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
      take("rlf");
      issue(4'd9, 8'h01, 8'h00, 1'b0);
      check_out("rrf", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
      take("rrf");
      issue(4'd10, 8'hA5, 8'h00, 1'b0);
      check_out("swap", 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0);
      take("swap");

      issue(4'd2, 8'hF0, 8'h3C, 1'b0);
      check_out("xor", 8'hCC, 8'h00, 1'b1, 1'b1, 1'b0);
      take("xor");
      issue(4'd1, 8'hF0, 8'h3C, 1'b0);
      check_out("and", 8'h30, 8'h00, 1'b1, 1'b1, 1'b0);
      take("and");
      issue(4'd0, 8'hF0, 8'h3C, 1'b0);
      check_out("ior", 8'hFC, 8'h00, 1'b1, 1'b1, 1'b0);
      take("ior");
      issue(4'd3, 8'h0F, 8'h00, 1'b0);
      check_out("comp", 8'hF0, 8'h00, 1'b1, 1'b1, 1'b0);
      take("comp");
      issue(4'd12, 8'h77, 8'h00, 1'b0);
      check_out("clr", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
      take("clr");
      issue(4'd7, 8'h00, 8'h00, 1'b0);
      check_out("dec", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
      take("dec");
      issue(4'd11, 8'h42, 8'h00, 1'b0);
      check_out("mov", 8'h42, 8'h00, 1'b1, 1'b1, 1'b0);
      take("mov");
      issue(4'd14, 8'h37, 8'h00, 1'b0);
      check_out("rsvd14", 8'h37, 8'h00, 1'b1, 1'b1, 1'b0);
      take("rsvd14");
      issue(4'd5, 8'h03, 8'h05, 1'b0);
      check_out("sub_borrow", 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
      take("sub_borrow");

      issue(4'd4, 8'hFF, 8'h04, 1'b0);
      check_out("hold_add", 8'h03, 8'h00, 1'b1, 1'b1, 1'b0);
      bus_if.in_valid = 1'b1;
      bus_if.op       = 4'd5;
      bus_if.op_a     = 8'h55;
      bus_if.op_b     = 8'h11;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_out($sformatf("hold%0d", i), 8'h03, 8'h00, 1'b1, 1'b1, 1'b0);
         check($sformatf("hold%0d in_ready", i), 16'(bus_if.in_ready), 16'd0);
      end
      bus_if.in_valid = 1'b0;
      take("hold");
      check("hold no new accept result", 16'(bus_if.result), 16'h0003);

      issue(4'd13, 8'h03, 8'h05, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("rst mid-mul out_valid", 16'(bus_if.out_valid), 16'd0);
      check("rst mid-mul result",    16'(bus_if.result),    16'd0);
      check("rst mid-mul result_hi", 16'(bus_if.result_hi), 16'd0);
      check("rst mid-mul flags",     16'({bus_if.c_new, bus_if.dc_new, bus_if.z_new}), 16'd0);
      rst = 1'b0;
      tick();
      check("post-rst in_ready", 16'(bus_if.in_ready), 16'd1);
      for (int i = 1; i <= 10; i++) begin
         check($sformatf("post-rst quiet%0d", i), 16'(bus_if.out_valid), 16'd0);
         tick();
      end
      issue(4'd4, 8'h01, 8'h01, 1'b0);
      check_out("post-rst add", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
      take("post-rst add");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
